psum_drain_seq: RTL and testbench

//  Drains a contiguous range of PSUM buffer rows and streams them, in address order, to the element unit.

---
 rtl/psum_drain_seq_if.sv | 32 +++
 rtl/psum_drain_seq.sv | 139 +++++++++++++
 tb/tb_psum_drain_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_seq_if.sv
// Bundle of signals between the PSUM drain sequencer, its controller, the PSUM
// buffer read port and the element unit. The master side is the sequencer.
interface psum_drain_seq_if #(
   parameter int DATA_W    = 256,
   parameter int ROWS_LOG2 = 6
);
   logic                 start;
   logic [ROWS_LOG2-1:0] base_addr;
   logic [ROWS_LOG2:0]   num_rows;
   logic                 busy;
   logic                 done;
   logic                 psum_rd_en;
   logic [ROWS_LOG2-1:0] psum_rd_addr;
   logic [DATA_W-1:0]    psum_rd_data;
   logic                 drain_valid;
   logic                 drain_ready;
   logic [DATA_W-1:0]    drain_data;
   logic [ROWS_LOG2-1:0] drain_addr;
   logic                 drain_last;

   modport master (
      input  start, base_addr, num_rows, psum_rd_data, drain_ready,
      output busy, done, psum_rd_en, psum_rd_addr,
             drain_valid, drain_data, drain_addr, drain_last
   );

   modport slave (
      output start, base_addr, num_rows, psum_rd_data, drain_ready,
      input  busy, done, psum_rd_en, psum_rd_addr,
             drain_valid, drain_data, drain_addr, drain_last
   );
endinterface

// File: rtl/psum_drain_seq.sv
// Streams a contiguous (wrapping) range of PSUM buffer rows to the element unit,
// hiding the one-cycle SRAM read latency behind a 2-entry fall-through skid FIFO.
module psum_drain_seq #(
   parameter int DATA_W    = 256,
   parameter int ROWS_LOG2 = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   psum_drain_seq_if.master  io_bus
);

   localparam logic [ROWS_LOG2:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t               r_state;
   logic [ROWS_LOG2-1:0] r_base;
   logic [ROWS_LOG2:0]   r_numRows;
   logic [ROWS_LOG2:0]   r_issued;
   logic [ROWS_LOG2:0]   r_sent;
   logic                 r_inflight;
   logic [ROWS_LOG2-1:0] r_inflightAddr;
   logic [DATA_W-1:0]    r_fifoData [2];
   logic [ROWS_LOG2-1:0] r_fifoAddr [2];
   logic                 r_rdPtr;
   logic                 r_wrPtr;
   logic [1:0]           r_count;

   logic                 w_fifoEmpty;
   logic                 w_valid;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_popStore;
   logic [2:0]           w_occupancy;
   logic                 w_rdEn;
   logic [ROWS_LOG2-1:0] w_rdAddr;
   logic [ROWS_LOG2:0]   w_numMinus1;
   logic                 w_lastIssue;
   logic                 w_lastXfer;
   logic [DATA_W-1:0]    w_headData;
   logic [ROWS_LOG2-1:0] w_headAddr;

   // The read returning this cycle counts as already in the FIFO, so an empty
   // FIFO presents the SRAM data directly and only stores it if not accepted.
   assign w_fifoEmpty = (r_count == 2'd0);
   assign w_valid     = !w_fifoEmpty || r_inflight;
   assign w_pop       = w_valid && io_bus.drain_ready;
   assign w_popStore  = w_pop && !w_fifoEmpty;
   assign w_push      = r_inflight && !(w_fifoEmpty && w_pop);
   assign w_headData  = w_fifoEmpty ? io_bus.psum_rd_data : r_fifoData[r_rdPtr];
   assign w_headAddr  = w_fifoEmpty ? r_inflightAddr : r_fifoAddr[r_rdPtr];

   assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_rdEn      = (r_state == RUN) && (r_issued < r_numRows)
                        && (w_occupancy < (3'd2 + {2'b00, w_pop}));
   assign w_rdAddr    = r_base + r_issued[ROWS_LOG2-1:0];
   assign w_numMinus1 = r_numRows - ONE;
   assign w_lastIssue = w_rdEn && (r_issued == w_numMinus1);
   assign w_lastXfer  = w_pop && (r_sent == w_numMinus1);

   assign io_bus.busy         = (r_state == RUN) || (r_state == FLUSH);
   assign io_bus.done         = (r_state == DONE);
   assign io_bus.psum_rd_en   = w_rdEn;
   assign io_bus.psum_rd_addr = w_rdEn ? w_rdAddr : '0;
   assign io_bus.drain_valid  = w_valid;
   assign io_bus.drain_data   = w_valid ? w_headData : '0;
   assign io_bus.drain_addr   = w_valid ? w_headAddr : '0;
   assign io_bus.drain_last   = w_valid && (r_sent == w_numMinus1);

   // Sequencer, counters and FIFO bookkeeping; reset drops any in-flight read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_base         <= '0;
         r_numRows      <= '0;
         r_issued       <= '0;
         r_sent         <= '0;
         r_inflight     <= 1'b0;
         r_inflightAddr <= '0;
         r_rdPtr        <= 1'b0;
         r_wrPtr        <= 1'b0;
         r_count        <= 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.start) begin
                  r_base    <= io_bus.base_addr;
                  r_numRows <= io_bus.num_rows;
                  r_issued  <= '0;
                  r_sent    <= '0;
                  r_state   <= (io_bus.num_rows == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_lastIssue) begin
                  r_state <= FLUSH;
               end
            end
            FLUSH: begin
               if (w_lastXfer) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (w_rdEn) begin
            r_issued <= r_issued + ONE;
         end
         if (w_pop) begin
            r_sent <= r_sent + ONE;
         end
         r_inflight     <= w_rdEn;
         r_inflightAddr <= w_rdAddr;

         if (w_push) begin
            r_wrPtr <= ~r_wrPtr;
         end
         if (w_popStore) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_popStore};
      end
   end

   // Row storage needs no reset: occupancy is tracked by r_count alone.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifoData[r_wrPtr] <= io_bus.psum_rd_data;
         r_fifoAddr[r_wrPtr] <= r_inflightAddr;
      end
   end

endmodule

// File: tb/tb_psum_drain_seq.sv
// Bench for psum_drain_seq: an SRAM model, a row-order scoreboard built from plain
// address arithmetic, a table of drain jobs and hand-written corner sequences.
module tb_psum_drain_seq;

   localparam int DATA_W    = 256;
   localparam int ROWS_LOG2 = 6;
   localparam int NROWS     = 64;

   typedef struct {
      logic [ROWS_LOG2-1:0] addr;
      logic [DATA_W-1:0]    data;
   } row_t;

   typedef struct {
      int base;
      int num;
      int pct;
      int expLastCnt;
      int expLastAddr;
      int expCycles;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   psum_drain_seq_if #(.DATA_W(DATA_W), .ROWS_LOG2(ROWS_LOG2)) bus ();

   psum_drain_seq #(.DATA_W(DATA_W), .ROWS_LOG2(ROWS_LOG2)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0]    mem [NROWS];
   row_t                 expQ [$];
   int                   nCompared = 0;
   int                   nMismatch = 0;
   int                   xfers, rdIssued, lastCount, doneCount;
   logic [ROWS_LOG2-1:0] lastAddr;
   logic                 held;
   logic [ROWS_LOG2-1:0] heldAddr;
   logic [DATA_W-1:0]    heldData;

   // SRAM model: data appears the cycle after the read; junk otherwise.
   always @(posedge clk) begin
      bus.psum_rd_data <= bus.psum_rd_en ? mem[bus.psum_rd_addr] : {8{$urandom}};
   end

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCounters();
      xfers     = 0;
      rdIssued  = 0;
      lastCount = 0;
      doneCount = 0;
      lastAddr  = '0;
   endtask

   // Pulses start; an accepted drain queues its rows in wrapped address order.
   task automatic applyStimulus(input int base, input int num, input bit expectAccept);
      bus.start     = 1'b1;
      bus.base_addr = 6'(base);
      bus.num_rows  = 7'(num);
      if (expectAccept) begin
         for (int i = 0; i < num; i++) begin
            expQ.push_back('{addr: 6'((base + i) % NROWS), data: mem[(base + i) % NROWS]});
         end
      end
      tick();
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input int pct, input int budget, output int cycles);
      cycles = 1;
      while (!bus.done && cycles < budget) begin
         bus.drain_ready = ($urandom_range(99) < pct);
         tick();
         cycles++;
      end
      if (!bus.done) begin
         nCompared++;
         nMismatch++;
         $display("[TB] FAIL done_timeout: done=%0b after %0d cycles, required 1", bus.done, cycles);
      end
   endtask

   task automatic runJob(input int base, input int num, input int pct, output int cycles);
      clearCounters();
      applyStimulus(base, num, 1'b1);
      waitDone(pct, 2000, cycles);
      tick();
      checkOutput("done_pulse_width", bus.done, 0);
      checkOutput("done_count", doneCount, 1);
      checkOutput("rows_left", expQ.size(), 0);
      checkOutput("rd_issued", rdIssued, num);
      checkOutput("xfers", xfers, num);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_done"}, bus.done, 0);
      checkOutput({tag, "_rd_en"}, bus.psum_rd_en, 0);
      checkOutput({tag, "_rd_addr"}, bus.psum_rd_addr, 0);
      checkOutput({tag, "_valid"}, bus.drain_valid, 0);
      checkOutput({tag, "_last"}, bus.drain_last, 0);
      checkOutput({tag, "_addr"}, bus.drain_addr, 0);
      checkOutput({tag, "_data"}, bus.drain_data, 0);
   endtask

   // Monitor: order/last scoreboard, stall stability, read and done counting.
   initial begin : monitor
      row_t e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               checkOutput("hold_valid", bus.drain_valid, 1);
               checkOutput("hold_addr", bus.drain_addr, heldAddr);
               checkOutput("hold_data", bus.drain_data, heldData);
            end
            if (bus.psum_rd_en) rdIssued++;
            if (bus.done) doneCount++;
            if (bus.drain_valid && bus.drain_ready) begin
               xfers++;
               if (expQ.size() == 0) begin
                  nCompared++;
                  nMismatch++;
                  $display("[TB] FAIL unexpected_row: got addr %0h, required no transfer", bus.drain_addr);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("row_addr", bus.drain_addr, e.addr);
                  checkOutput("row_data", bus.drain_data, e.data);
                  checkOutput("row_last", bus.drain_last, expQ.size() == 0);
               end
               if (bus.drain_last) begin
                  lastCount++;
                  lastAddr = bus.drain_addr;
               end
            end
            held     = bus.drain_valid && !bus.drain_ready;
            heldAddr = bus.drain_addr;
            heldData = bus.drain_data;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      vec_t vecs [8];
      int   cycles;
      int   base, num, pct;

      vecs[0] = '{base: 0,  num: 4,  pct: 100, expLastCnt: 1, expLastAddr: 3,  expCycles: 6};
      vecs[1] = '{base: 62, num: 4,  pct: 100, expLastCnt: 1, expLastAddr: 1,  expCycles: 6};
      vecs[2] = '{base: 7,  num: 0,  pct: 100, expLastCnt: 0, expLastAddr: 0,  expCycles: 1};
      vecs[3] = '{base: 10, num: 1,  pct: 50,  expLastCnt: 1, expLastAddr: 10, expCycles: -1};
      vecs[4] = '{base: 5,  num: 64, pct: 50,  expLastCnt: 1, expLastAddr: 4,  expCycles: -1};
      vecs[5] = '{base: 63, num: 2,  pct: 30,  expLastCnt: 1, expLastAddr: 0,  expCycles: -1};
      vecs[6] = '{base: 20, num: 17, pct: 100, expLastCnt: 1, expLastAddr: 36, expCycles: 19};
      vecs[7] = '{base: 0,  num: 64, pct: 100, expLastCnt: 1, expLastAddr: 63, expCycles: 66};

      for (int i = 0; i < NROWS; i++) begin
         mem[i] = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      end
      bus.start       = 1'b0;
      bus.base_addr   = '0;
      bus.num_rows    = '0;
      bus.drain_ready = 1'b0;
      clearCounters();

      $display("[TB] reset state");
      rst = 1'b1;
      repeat (3) tick();
      checkIdleOutputs("reset");
      rst = 1'b0;
      tick();

      $display("[TB] cycle-exact drain base=0 num=4");
      clearCounters();
      bus.drain_ready = 1'b1;
      applyStimulus(0, 4, 1'b1);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         checkOutput($sformatf("c%0d_rd_en", cyc), bus.psum_rd_en, (cyc <= 4));
         if (cyc <= 4) checkOutput($sformatf("c%0d_rd_addr", cyc), bus.psum_rd_addr, cyc - 1);
         checkOutput($sformatf("c%0d_valid", cyc), bus.drain_valid, (cyc >= 2 && cyc <= 5));
         if (cyc >= 2 && cyc <= 5) checkOutput($sformatf("c%0d_addr", cyc), bus.drain_addr, cyc - 2);
         checkOutput($sformatf("c%0d_last", cyc), bus.drain_last, (cyc == 5));
         checkOutput($sformatf("c%0d_done", cyc), bus.done, (cyc == 6));
         checkOutput($sformatf("c%0d_busy", cyc), bus.busy, (cyc <= 5));
         tick();
      end
      checkOutput("c_rows_left", expQ.size(), 0);

      $display("[TB] table-driven drains");
      for (int i = 0; i < 8; i++) begin
         runJob(vecs[i].base, vecs[i].num, vecs[i].pct, cycles);
         checkOutput($sformatf("v%0d_last_count", i), lastCount, vecs[i].expLastCnt);
         if (vecs[i].expLastCnt > 0) checkOutput($sformatf("v%0d_last_addr", i), lastAddr, vecs[i].expLastAddr);
         if (vecs[i].expCycles >= 0) checkOutput($sformatf("v%0d_latency", i), cycles, vecs[i].expCycles);
      end

      $display("[TB] stall with ready low for 10 cycles");
      clearCounters();
      bus.drain_ready = 1'b0;
      applyStimulus(40, 3, 1'b1);
      tick();
      checkOutput("stall_first_valid", bus.drain_valid, 1);
      repeat (10) tick();
      checkOutput("stall_reads", rdIssued, 2);
      checkOutput("stall_no_xfer", xfers, 0);
      waitDone(100, 50, cycles);
      tick();
      checkOutput("stall_xfers", xfers, 3);
      checkOutput("stall_rows_left", expQ.size(), 0);
      checkOutput("stall_done_count", doneCount, 1);

      $display("[TB] start while busy and while done");
      clearCounters();
      bus.drain_ready = 1'b1;
      applyStimulus(0, 8, 1'b1);
      tick();
      tick();
      applyStimulus(30, 5, 1'b0);
      waitDone(100, 100, cycles);
      applyStimulus(9, 3, 1'b0);
      checkOutput("start_in_done_busy", bus.busy, 0);
      checkOutput("start_in_done_pulse", bus.done, 0);
      tick();
      checkOutput("ignored_start_busy", bus.busy, 0);
      checkOutput("ignored_start_rd_en", bus.psum_rd_en, 0);
      checkOutput("ignored_start_xfers", xfers, 8);
      checkOutput("ignored_start_reads", rdIssued, 8);
      checkOutput("ignored_start_done_count", doneCount, 1);
      checkOutput("ignored_start_rows_left", expQ.size(), 0);

      $display("[TB] reset mid-drain");
      clearCounters();
      bus.drain_ready = 1'b1;
      applyStimulus(0, 10, 1'b1);
      for (int k = 0; k < 20 && xfers < 2; k++) tick();
      checkOutput("pre_reset_xfers", xfers, 2);
      rst             = 1'b1;
      bus.drain_ready = 1'b0;
      expQ.delete();
      tick();
      checkIdleOutputs("mid_reset");
      rst = 1'b0;
      tick();
      checkIdleOutputs("post_reset");
      checkOutput("post_reset_done_count", doneCount, 0);
      runJob(50, 6, 60, cycles);
      checkOutput("post_reset_last_addr", lastAddr, 55);

      $display("[TB] randomized drains");
      for (int i = 0; i < 6; i++) begin
         base = $urandom_range(NROWS - 1);
         num  = $urandom_range(NROWS);
         pct  = $urandom_range(100, 20);
         runJob(base, num, pct, cycles);
         checkOutput($sformatf("r%0d_last_count", i), lastCount, (num > 0) ? 1 : 0);
         if (num > 0) checkOutput($sformatf("r%0d_last_addr", i), lastAddr, (base + num - 1) % NROWS);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
